// File: rtl/relu_pkg.sv
// ----------------------------------------------------------------------------
// relu_pkg
// Shared constants and helpers for the relu_requant block.
//   SAT_CNT_W / SAT_CNT_MAX : width and ceiling of the saturation beat counter
//   sat_max() / sat_min()   : signed clamp bounds for an out_w-bit output
// The bounds are returned on 64 bits so callers can compare any internal
// width up to 64 bits against them without truncation.
// ----------------------------------------------------------------------------
package relu_pkg;

    localparam int              SAT_CNT_W   = 16;
    localparam logic [15:0]     SAT_CNT_MAX = 16'hFFFF;

    // Largest representable value of a signed out_w-bit number.
    function automatic logic signed [63:0] sat_max(input int out_w);
        logic signed [63:0] one;
        one     = 64'sd1;
        sat_max = (one <<< (out_w - 1)) - 64'sd1;
    endfunction

    // Most negative representable value of a signed out_w-bit number.
    function automatic logic signed [63:0] sat_min(input int out_w);
        logic signed [63:0] one;
        one     = 64'sd1;
        sat_min = -(one <<< (out_w - 1));
    endfunction

endpackage

// File: rtl/relu_requant_lane.sv
// ----------------------------------------------------------------------------
// relu_requant_lane
// Combinational per-lane datapath: activation, round-half-up right shift,
// signed saturation and the lane saturation bit.
//   i_x     : signed accumulator value (IN_W)
//   i_shift : requant right shift (SHIFT_W), clamped to IN_W-1
//   o_y     : saturated signed result (OUT_W)
//   o_sat   : 1 when o_y was clamped
// Build option: RELU_REQUANT_LEAKY_EN selects a leaky negative slope
// (x >>> LEAK_SHIFT) instead of clamping negatives to zero.
// ----------------------------------------------------------------------------
module relu_requant_lane
    import relu_pkg::*;
#(
    parameter int IN_W       = 32,
    parameter int OUT_W      = 16,
    parameter int SHIFT_W    = 5,
    parameter int LEAK_SHIFT = 3
) (
    input  logic [IN_W-1:0]    i_x,
    input  logic [SHIFT_W-1:0] i_shift,
    output logic [OUT_W-1:0]   o_y,
    output logic               o_sat
);

    // One extra bit of headroom so the rounding add can never overflow.
    localparam int AW = IN_W + 1;

    localparam logic signed [AW-1:0] ONE_AW   = {{(AW-1){1'b0}}, 1'b1};
    localparam logic signed [63:0]   MAX64    = sat_max(OUT_W);
    localparam logic signed [63:0]   MIN64    = sat_min(OUT_W);
    localparam logic [OUT_W-1:0]     MAX_OUT  = MAX64[OUT_W-1:0];
    localparam logic [OUT_W-1:0]     MIN_OUT  = MIN64[OUT_W-1:0];

    // The leak shift must leave at least the sign bit of the accumulator.
    if (LEAK_SHIFT < 0 || LEAK_SHIFT >= IN_W) begin : g_leak_shift_range
        $error("relu_requant_lane: LEAK_SHIFT out of range");
    end

    logic signed [AW-1:0] w_x_ext;
    logic signed [AW-1:0] w_a;
    logic        [31:0]   w_s;
    logic signed [AW-1:0] w_rnd;
    logic signed [AW-1:0] w_sum;
    logic signed [AW-1:0] w_r;
    logic signed [63:0]   w_r64;

    assign w_x_ext = {i_x[IN_W-1], i_x};

    // Activation: sign decision on this lane only.
    always_comb begin
        w_a = w_x_ext;
        if (w_x_ext[AW-1]) begin
`ifdef RELU_REQUANT_LEAKY_EN
            w_a = w_x_ext >>> LEAK_SHIFT;
`else
            w_a = '0;
`endif
        end else begin
            w_a = w_x_ext;
        end
    end

    // Shift clamp and round-half-up: add half an LSB of the result, then shift.
    always_comb begin
        w_s = 32'(i_shift);
        if (w_s > 32'(IN_W - 1)) begin
            w_s = 32'(IN_W - 1);
        end else begin
            w_s = 32'(i_shift);
        end
        if (w_s != 32'd0) begin
            w_rnd = ONE_AW << (w_s - 32'd1);
        end else begin
            w_rnd = '0;
        end
        w_sum = w_a + w_rnd;
        w_r   = w_sum >>> w_s;
    end

    assign w_r64 = {{(64 - AW){w_r[AW-1]}}, w_r};

    // Saturation to the signed output range; the negative branch is kept even
    // when the pure ReLU build cannot reach it.
    always_comb begin
        o_y   = w_r[OUT_W-1:0];
        o_sat = 1'b0;
        if (w_r64 > MAX64) begin
            o_y   = MAX_OUT;
            o_sat = 1'b1;
        end else if (w_r64 < MIN64) begin
            o_y   = MIN_OUT;
            o_sat = 1'b1;
        end else begin
            o_y   = w_r[OUT_W-1:0];
            o_sat = 1'b0;
        end
    end

endmodule

// File: rtl/relu_requant.sv
// ----------------------------------------------------------------------------
// relu_requant
// Multi-channel ReLU + requantisation stage with a 2-stage valid/ready
// pipeline and a sticky saturation monitor.
//   clk, rst_n           : clock, asynchronous active-low reset
//   in_valid/in_ready    : input handshake; in_data holds CH lanes of IN_W
//   shift                : requant right shift, captured with the beat
//   out_valid/out_ready  : output handshake; out_data holds CH lanes of OUT_W
//   sat_clr              : synchronous clear of sat_flag / sat_cnt
//   sat_flag, sat_cnt    : sticky flag and saturating count of output beats
//                          that carried at least one clamped lane
// Build option: RELU_REQUANT_LEAKY_EN (leaky negative slope, see lane).
// S1 holds the raw beat and its shift; the lane datapath sits between S1 and
// S2, and S2 holds the finished beat plus its saturation bit.
// ----------------------------------------------------------------------------
module relu_requant
    import relu_pkg::*;
#(
    parameter int CH         = 3,
    parameter int IN_W       = 32,
    parameter int OUT_W      = 16,
    parameter int SHIFT_W    = 5,
    parameter int LEAK_SHIFT = 3
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [CH*IN_W-1:0]    in_data,
    input  logic [SHIFT_W-1:0]    shift,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [CH*OUT_W-1:0]   out_data,
    input  logic                  sat_clr,
    output logic                  sat_flag,
    output logic [SAT_CNT_W-1:0]  sat_cnt
);

    logic                  r_s1_valid;
    logic [CH*IN_W-1:0]    r_s1_data;
    logic [SHIFT_W-1:0]    r_s1_shift;
    logic                  r_s2_valid;
    logic [CH*OUT_W-1:0]   r_s2_data;
    logic                  r_s2_sat;
    logic                  r_sat_flag;
    logic [SAT_CNT_W-1:0]  r_sat_cnt;

    logic                  w_s2_load;
    logic                  w_s1_load;
    logic [CH*OUT_W-1:0]   w_lane_y;
    logic [CH-1:0]         w_lane_sat;
    logic                  w_hs_sat;

    // Elastic control: in_ready depends only on register state and out_ready.
    assign w_s2_load = !r_s2_valid || out_ready;
    assign w_s1_load = !r_s1_valid || w_s2_load;
    assign in_ready  = w_s1_load;
    assign w_hs_sat  = r_s2_valid && out_ready && r_s2_sat;

    for (genvar k = 0; k < CH; k++) begin : g_lane
        relu_requant_lane #(
            .IN_W       (IN_W),
            .OUT_W      (OUT_W),
            .SHIFT_W    (SHIFT_W),
            .LEAK_SHIFT (LEAK_SHIFT)
        ) u_lane (
            .i_x     (r_s1_data[k*IN_W +: IN_W]),
            .i_shift (r_s1_shift),
            .o_y     (w_lane_y[k*OUT_W +: OUT_W]),
            .o_sat   (w_lane_sat[k])
        );
    end

    // S1: capture the raw beat and its shift.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_s1_valid <= 1'b0;
            r_s1_data  <= '0;
            r_s1_shift <= '0;
        end else if (w_s1_load) begin
            r_s1_valid <= in_valid;
            if (in_valid) begin
                r_s1_data  <= in_data;
                r_s1_shift <= shift;
            end
        end
    end

    // S2: capture the requantised beat and its beat-level saturation bit.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_s2_valid <= 1'b0;
            r_s2_data  <= '0;
            r_s2_sat   <= 1'b0;
        end else if (w_s2_load) begin
            r_s2_valid <= r_s1_valid;
            if (r_s1_valid) begin
                r_s2_data <= w_lane_y;
                r_s2_sat  <= |w_lane_sat;
            end
        end
    end

    // Saturation monitor; a clear coinciding with a saturating handshake
    // leaves that handshake counted.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sat_flag <= 1'b0;
            r_sat_cnt  <= '0;
        end else if (sat_clr) begin
            r_sat_flag <= w_hs_sat;
            r_sat_cnt  <= w_hs_sat ? {{(SAT_CNT_W-1){1'b0}}, 1'b1} : '0;
        end else if (w_hs_sat) begin
            r_sat_flag <= 1'b1;
            if (r_sat_cnt != SAT_CNT_MAX) begin
                r_sat_cnt <= r_sat_cnt + {{(SAT_CNT_W-1){1'b0}}, 1'b1};
            end
        end
    end

    assign out_valid = r_s2_valid;
    assign out_data  = r_s2_data;
    assign sat_flag  = r_sat_flag;
    assign sat_cnt   = r_sat_cnt;

endmodule

// File: tb/tb_relu_requant.sv
// ----------------------------------------------------------------------------
// tb_relu_requant
// Scoreboard bench for relu_requant: expected beats are computed by an
// arithmetic reference model when a beat is accepted and compared when the
// DUT hands the beat out. The saturation monitor is modelled cycle by cycle.
// ----------------------------------------------------------------------------
module tb_relu_requant;

    localparam int CH      = 3;
    localparam int IN_W    = 32;
    localparam int OUT_W   = 16;
    localparam int SHIFT_W = 5;
    localparam int LEAK    = 3;

    typedef struct {
        logic [CH*OUT_W-1:0] d;
        bit                  sat;
    } exp_t;

    logic                 clk = 1'b0;
    logic                 rst_n;
    logic                 in_valid;
    logic                 in_ready;
    logic [CH*IN_W-1:0]   in_data;
    logic [SHIFT_W-1:0]   shift;
    logic                 out_valid;
    logic                 out_ready;
    logic [CH*OUT_W-1:0]  out_data;
    logic                 sat_clr;
    logic                 sat_flag;
    logic [15:0]          sat_cnt;

    exp_t        sb_q[$];
    int          n_checks = 0;
    int          n_errors = 0;
    logic [15:0] exp_cnt  = 16'd0;
    logic        exp_flag = 1'b0;
    bit          rand_rdy = 1'b0;

    relu_requant #(
        .CH(CH), .IN_W(IN_W), .OUT_W(OUT_W), .SHIFT_W(SHIFT_W), .LEAK_SHIFT(LEAK)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .shift(shift),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .sat_clr(sat_clr), .sat_flag(sat_flag), .sat_cnt(sat_cnt)
    );

    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [95:0] got, input logic [95:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got=%h expected=%h", tag, got, exp);
        end
    endtask

    function automatic longint floor_div(input longint n, input longint d);
        longint q;
        q = n / d;
        if ((n % d != 0) && (n < 0)) q = q - 1;
        return q;
    endfunction

    // Reference: integer arithmetic on 64 bits, floor semantics for shifts.
    function automatic void ref_beat(input logic [CH*IN_W-1:0] d, input logic [SHIFT_W-1:0] sh,
                                     output logic [CH*OUT_W-1:0] o, output bit sat);
        longint x, a, p, r, s;
        logic [IN_W-1:0] lane;
        logic [63:0]     rb;
        sat = 0;
        o   = '0;
        for (int k = 0; k < CH; k++) begin
            lane = d[k*IN_W +: IN_W];
            x = longint'($signed(lane));
`ifdef RELU_REQUANT_LEAKY_EN
            a = (x < 0) ? floor_div(x, longint'(1) << LEAK) : x;
`else
            a = (x < 0) ? 0 : x;
`endif
            s = (longint'(sh) > IN_W - 1) ? IN_W - 1 : longint'(sh);
            p = longint'(1) << s;
            r = (s > 0) ? floor_div(a + p / 2, p) : a;
            if (r > 32767) begin
                r = 32767; sat = 1;
            end else if (r < -32768) begin
                r = -32768; sat = 1;
            end
            rb = 64'(r);
            o[k*OUT_W +: OUT_W] = rb[15:0];
        end
    endfunction

    // Output side: scoreboard pop and saturation-monitor model.
    always @(negedge clk) begin
        exp_t e;
        bit   hs_sat;
        if (!rst_n) begin
            sb_q.delete();
            exp_cnt  = 16'd0;
            exp_flag = 1'b0;
        end else begin
            check_val("sat_cnt", 96'(sat_cnt), 96'(exp_cnt));
            check_val("sat_flag", 96'(sat_flag), 96'(exp_flag));
            hs_sat = 0;
            if (out_valid && out_ready) begin
                if (sb_q.size() == 0) begin
                    check_val("sb_underflow", 96'(sb_q.size()), 96'd1);
                end else begin
                    e = sb_q.pop_front();
                    check_val("out_data", 96'(out_data), 96'(e.d));
                    hs_sat = e.sat;
                end
            end
            if (sat_clr) begin
                exp_flag = hs_sat;
                exp_cnt  = hs_sat ? 16'd1 : 16'd0;
            end else if (hs_sat) begin
                exp_flag = 1'b1;
                if (exp_cnt != 16'hFFFF) exp_cnt = exp_cnt + 16'd1;
            end
        end
    end

    task automatic drive_beat(input logic [31:0] l0, input logic [31:0] l1, input logic [31:0] l2,
                              input logic [SHIFT_W-1:0] sh);
        in_data  = {l2, l1, l0};
        shift    = sh;
        in_valid = 1'b1;
    endtask

    // Waits for the driven beat to be taken; pushes its expected result.
    task automatic wait_accept();
        bit   ok = 0;
        exp_t e;
        for (int i = 0; i < 60 && !ok; i++) begin
            @(negedge clk);
            if (in_ready) begin
                ok = 1;
                ref_beat(in_data, shift, e.d, e.sat);
                sb_q.push_back(e);
            end
            @(posedge clk);
            #1;
            if (rand_rdy) out_ready = ($urandom_range(0, 3) != 0);
        end
        in_valid = 1'b0;
        check_val("accept_timeout", 96'(ok), 96'd1);
    endtask

    task automatic send(input logic [31:0] l0, input logic [31:0] l1, input logic [31:0] l2,
                        input logic [SHIFT_W-1:0] sh);
        drive_beat(l0, l1, l2, sh);
        wait_accept();
    endtask

    task automatic wait_drain();
        for (int i = 0; i < 100 && sb_q.size() != 0; i++) @(negedge clk);
        check_val("drain_timeout", 96'(sb_q.size()), 96'd0);
        @(posedge clk);
        #1;
    endtask

    function automatic logic [31:0] rand_lane();
        case ($urandom_range(0, 4))
            0:       return $urandom;
            1:       return 32'($urandom_range(0, 65535));
            2:       return -32'($urandom_range(1, 4096));
            3:       return 32'h7FFF_FFFF;
            default: return 32'h8000_0000;
        endcase
    endfunction

    initial begin
        logic [CH*OUT_W-1:0] held;
        bit                  dummy;
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        in_data   = '0;
        shift     = '0;
        out_ready = 1'b1;
        sat_clr   = 1'b0;

        #1;
        check_val("rst_out_valid", 96'(out_valid), 96'd0);
        check_val("rst_out_data", 96'(out_data), 96'd0);
        check_val("rst_sat_flag", 96'(sat_flag), 96'd0);
        check_val("rst_sat_cnt", 96'(sat_cnt), 96'd0);
        @(posedge clk);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(negedge clk);
        check_val("rst_in_ready", 96'(in_ready), 96'd1);
        @(posedge clk);
        #1;

        // Basic beat and exact 2-cycle latency.
        send(32'h0001_2380, 32'hFFFF_FF00, 32'h0000_00FF, 5'd8);
        @(negedge clk);
        check_val("lat_edge1_valid", 96'(out_valid), 96'd0);
        @(negedge clk);
        check_val("lat_edge2_valid", 96'(out_valid), 96'd1);
        check_val("basic_data", 96'(out_data), 96'h0001_0000_0124);
        wait_drain();
        check_val("basic_sat_cnt", 96'(sat_cnt), 96'd0);

        // Lane independence.
        send(32'h8000_0000, 32'h0000_0200, 32'h0000_0300, 5'd8);
        wait_drain();

        // Saturation, then clear coinciding with a saturating handshake.
        send(32'h0100_0000, 32'h0, 32'h0, 5'd8);
        wait_drain();
        check_val("sat1_flag", 96'(sat_flag), 96'd1);
        check_val("sat1_cnt", 96'(sat_cnt), 96'd1);
        send(32'h0100_0000, 32'h0, 32'h0, 5'd8);
        @(posedge clk);
        #1;
        sat_clr = 1'b1;
        @(posedge clk);
        #1;
        sat_clr = 1'b0;
        check_val("clr_hs_cnt", 96'(sat_cnt), 96'd1);
        check_val("clr_hs_flag", 96'(sat_flag), 96'd1);
        wait_drain();

        // Backpressure: two beats fill the pipe, the third stalls.
        out_ready = 1'b0;
        send(32'h0000_1000, 32'h0000_2000, 32'h0000_3000, 5'd8);
        send(32'h0000_4000, 32'h0000_5000, 32'h0000_6000, 5'd8);
        ref_beat({32'h0000_3000, 32'h0000_2000, 32'h0000_1000}, 5'd8, held, dummy);
        drive_beat(32'h0000_0007, 32'h0000_0008, 32'h0000_0009, 5'd0);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check_val("bp_in_ready", 96'(in_ready), 96'd0);
            check_val("bp_out_valid", 96'(out_valid), 96'd1);
            check_val("bp_held_data", 96'(out_data), 96'(held));
        end
        @(posedge clk);
        #1;
        out_ready = 1'b1;
        wait_accept();
        send(32'h0000_0A00, 32'h0000_0B00, 32'h0000_0C00, 5'd4);
        send(32'h0000_0D00, 32'h0000_0E00, 32'h0000_0F00, 5'd31);
        wait_drain();

        // Negative lane with zero shift: leaky slope or clamp to zero.
        send(32'hFFFF_FF00, 32'h0000_0010, 32'h0000_7FFF, 5'd0);
        @(negedge clk);
        @(negedge clk);
`ifdef RELU_REQUANT_LEAKY_EN
        check_val("neg_lane0", 96'(out_data[15:0]), 96'h0000_FFE0);
`else
        check_val("neg_lane0", 96'(out_data[15:0]), 96'h0000_0000);
`endif
        wait_drain();

        // Random stream with random downstream stalls.
        rand_rdy = 1'b1;
        for (int i = 0; i < 40; i++) begin
            send(rand_lane(), rand_lane(), rand_lane(), 5'($urandom_range(0, 31)));
        end
        rand_rdy  = 1'b0;
        out_ready = 1'b1;
        wait_drain();

        // Clear without a handshake, then one saturating beat.
        sat_clr = 1'b1;
        @(posedge clk);
        #1;
        sat_clr = 1'b0;
        check_val("clr_only_cnt", 96'(sat_cnt), 96'd0);
        send(32'h7FFF_FFFF, 32'h0, 32'h0, 5'd2);
        wait_drain();
        check_val("pre_rst_cnt", 96'(sat_cnt), 96'd1);

        // Reset with two beats in flight.
        send(32'h0000_1100, 32'h0, 32'h0, 5'd8);
        send(32'h0000_2200, 32'h0, 32'h0, 5'd8);
        rst_n = 1'b0;
        #1;
        check_val("arst_out_valid", 96'(out_valid), 96'd0);
        check_val("arst_sat_cnt", 96'(sat_cnt), 96'd0);
        @(negedge clk);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(negedge clk);
        check_val("post_rst_in_ready", 96'(in_ready), 96'd1);
        @(posedge clk);
        #1;
        send(32'h0000_3300, 32'h0000_0001, 32'h0, 5'd8);
        @(negedge clk);
        @(negedge clk);
        check_val("post_rst_first", 96'(out_data), 96'h0000_0000_0033);
        wait_drain();

        check_val("sb_empty", 96'(sb_q.size()), 96'd0);
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL global_timeout: simulation did not complete");
        $fatal(1, "timeout");
    end

endmodule
